uart_rx_cfg: RTL and testbench

Parametrised UART receiver for the UART component: asynchronous serial input, double-flop synchronised, with configurable data width, parity mode and stop-bit count. Each bit is majority-voted over three mid-bit samples; parity, framing and line-break errors are flagged. It replaces the fixed 8N1 receiver in designs needing 7E1, 8O2 and similar formats, and presents the same done-tick/data handshake to the downstream consumer.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_bit_sampler.sv | 48 ++++
 rtl/uart_rx_cfg.sv | 125 ++++++++++++
 tb/tb_uart_rx_cfg.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Line synchroniser, per-bit cycle counter and 3-sample majority vote.
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 40
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rx,
  input  logic i_restart,
  output logic o_rxs,
  output logic o_bit_valid,
  output logic o_bit_val,
  output logic o_bit_end
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0] C_S0  = CW'(HALF - 1);
  localparam logic [CW-1:0] C_S1  = CW'(HALF);
  localparam logic [CW-1:0] C_RES = CW'(HALF + 1);
  localparam logic [CW-1:0] C_END = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    r_sync;
  logic [1:0]    r_smp;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
      r_smp  <= 2'b11;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_rx};
      if (i_restart || r_cnt == C_END) r_cnt <= '0;
      else                             r_cnt <= r_cnt + CW'(1);
      if (r_cnt == C_S0) r_smp[0] <= o_rxs;
      if (r_cnt == C_S1) r_smp[1] <= o_rxs;
    end
  end

  assign o_rxs = r_sync[1];
  // Third sample is the live synchronised line, so the vote resolves at HALF+1.
  assign o_bit_valid = !i_restart && (r_cnt == C_RES);
  assign o_bit_val   = maj3(r_smp[0], r_smp[1], o_rxs);
  assign o_bit_end   = (r_cnt == C_END);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: frame FSM, shift register, parity and error flags.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 40,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 rx_done_tick,
  output logic [DATA_BITS-1:0] dout,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  rx_state_e            r_state, w_next;
  logic [3:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err, r_stop_low, r_stop0_low;
  logic                 w_rxs, w_bit_valid, w_bit_val, w_bit_end, w_restart;
  logic                 w_last_stop, w_stop0_low, w_any_low, w_brk, w_done;

  uart_bit_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_smp (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rx       (rx),
    .i_restart  (w_restart),
    .o_rxs      (w_rxs),
    .o_bit_valid(w_bit_valid),
    .o_bit_val  (w_bit_val),
    .o_bit_end  (w_bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_restart   = 1'b0;
    w_done      = 1'b0;
    w_last_stop = (r_idx == 4'(STOP_BITS - 1));
    w_stop0_low = (r_idx == 4'd0) ? !w_bit_val : r_stop0_low;
    w_any_low   = r_stop_low | !w_bit_val;
    w_brk       = (r_shift == '0) && w_stop0_low;
    case (r_state)
      IDLE: begin
        w_restart = 1'b1;
        if (!w_rxs) w_next = START;
      end
      START:
        if (w_bit_valid && w_bit_val) w_next = IDLE;
        else if (w_bit_end)           w_next = DATA;
      DATA:
        if (w_bit_end && r_idx == 4'(DATA_BITS - 1))
          w_next = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
      PARITY:
        if (w_bit_end) w_next = STOP;
      // Leave at the last stop bit's vote so a following start edge is not missed.
      STOP:
        if (w_bit_valid && w_last_stop) begin
          w_done = 1'b1;
          w_next = w_brk ? BRK_WAIT : IDLE;
        end
      BRK_WAIT: begin
        w_restart = 1'b1;
        if (w_rxs) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_shift      <= '0;
      r_par_err    <= 1'b0;
      r_stop_low   <= 1'b0;
      r_stop0_low  <= 1'b0;
      rx_done_tick <= 1'b0;
      dout         <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      rx_done_tick <= w_done;
      case (r_state)
        IDLE, BRK_WAIT: begin
          r_idx       <= '0;
          r_par_err   <= 1'b0;
          r_stop_low  <= 1'b0;
          r_stop0_low <= 1'b0;
        end
        DATA: begin
          if (w_bit_valid) r_shift <= {w_bit_val, r_shift[DATA_BITS-1:1]};
          if (w_bit_end)
            r_idx <= (r_idx == 4'(DATA_BITS - 1)) ? 4'd0 : r_idx + 4'd1;
        end
        PARITY:
          if (w_bit_valid)
            r_par_err <= w_bit_val != ((^r_shift) ^ (PARITY_MODE == PAR_ODD));
        STOP: begin
          if (w_bit_valid) begin
            r_stop_low <= w_any_low;
            if (r_idx == 4'd0) r_stop0_low <= !w_bit_val;
          end
          if (w_bit_end) r_idx <= r_idx + 4'd1;
        end
        default: ;
      endcase
      if (w_done) begin
        dout       <= r_shift;
        parity_err <= r_par_err;
        frame_err  <= w_any_low;
        break_det  <= w_brk;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three formats (8E1, 7O2, 8N1) driven with directed and random frames.
module tb_uart_rx_cfg;
  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;

  typedef struct {
    int         cyc;
    logic [8:0] d;
    logic       p, f, b;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rx = 3'b111;
  logic [2:0] tick, perr, ferr, brk;
  logic [7:0] d_e1;
  logic [6:0] d_o2;
  logic [7:0] d_n1;
  int         cyc = 0;
  int         n_chk = 0, n_err = 0;
  rec_t       exp_q[3][$];
  rec_t       obs_q[3][$];
  int         db[3] = '{8, 7, 8};
  int         pm[3] = '{1, 2, 0};
  int         sb[3] = '{1, 2, 1};

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_e1 (
    .clk(clk), .rst_n(rst_n), .rx(rx[0]), .rx_done_tick(tick[0]), .dout(d_e1),
    .parity_err(perr[0]), .frame_err(ferr[0]), .break_det(brk[0]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_o2 (
    .clk(clk), .rst_n(rst_n), .rx(rx[1]), .rx_done_tick(tick[1]), .dout(d_o2),
    .parity_err(perr[1]), .frame_err(ferr[1]), .break_det(brk[1]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_n1 (
    .clk(clk), .rst_n(rst_n), .rx(rx[2]), .rx_done_tick(tick[2]), .dout(d_n1),
    .parity_err(perr[2]), .frame_err(ferr[2]), .break_det(brk[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic rec_t mk(input int c, input logic [8:0] d, input logic p, input logic f,
                              input logic b);
    rec_t r;
    r.cyc = c; r.d = d; r.p = p; r.f = f; r.b = b;
    return r;
  endfunction

  always @(negedge clk) begin
    if (tick[0]) obs_q[0].push_back(mk(cyc, {1'b0, d_e1}, perr[0], ferr[0], brk[0]));
    if (tick[1]) obs_q[1].push_back(mk(cyc, {2'b0, d_o2}, perr[1], ferr[1], brk[1]));
    if (tick[2]) obs_q[2].push_back(mk(cyc, {1'b0, d_n1}, perr[2], ferr[2], brk[2]));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_q(input int k, input string tag);
    int   n;
    rec_t o, e;
    chk($sformatf("%s[%0d] tick count", tag, k), obs_q[k].size(), exp_q[k].size());
    n = (obs_q[k].size() < exp_q[k].size()) ? obs_q[k].size() : exp_q[k].size();
    for (int i = 0; i < n; i++) begin
      o = obs_q[k][i];
      e = exp_q[k][i];
      chk($sformatf("%s[%0d].%0d cycle", tag, k, i), o.cyc, e.cyc);
      chk($sformatf("%s[%0d].%0d dout", tag, k, i), o.d, e.d);
      chk($sformatf("%s[%0d].%0d parity_err", tag, k, i), o.p, e.p);
      chk($sformatf("%s[%0d].%0d frame_err", tag, k, i), o.f, e.f);
      chk($sformatf("%s[%0d].%0d break_det", tag, k, i), o.b, e.b);
    end
    obs_q[k].delete();
    exp_q[k].delete();
  endtask

  // Always entered and left just after a rising edge, so cyc marks the line change.
  task automatic hold(input int k, input logic v, input int n);
    rx[k] = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // slo marks stop bits driven low; glitch >= 0 puts a 1-cycle high pulse mid data bit.
  task automatic send_frame(input int k, input logic [8:0] data, input logic flip,
                            input logic [1:0] slo, input int gap, input int glitch);
    rec_t       e;
    int         nb;
    logic       par;
    logic [8:0] dm;
    dm  = '0;
    par = (pm[k] == 2);
    for (int i = 0; i < db[k]; i++) begin
      dm[i] = data[i];
      par   = par ^ data[i];
    end
    nb    = 1 + db[k] + ((pm[k] != 0) ? 1 : 0) + sb[k];
    e.cyc = cyc + 3 + (nb - 1) * CPB + HALF + 2;
    e.d   = dm;
    e.p   = (pm[k] != 0) && flip;
    e.f   = slo[0] || (sb[k] == 2 && slo[1]);
    e.b   = (dm == 9'd0) && slo[0];
    exp_q[k].push_back(e);
    hold(k, 1'b0, CPB);
    for (int i = 0; i < db[k]; i++) begin
      if (i == glitch) begin
        hold(k, 1'b0, 7);
        hold(k, 1'b1, 1);
        hold(k, 1'b0, CPB - 8);
      end else begin
        hold(k, data[i], CPB);
      end
    end
    if (pm[k] != 0) hold(k, par ^ flip, CPB);
    for (int s = 0; s < sb[k]; s++) hold(k, !slo[s], CPB);
    if (gap > 0) hold(k, 1'b1, gap);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " tick"}, tick, 3'b000);
    chk({tag, " dout e1"}, d_e1, 8'h00);
    chk({tag, " dout o2"}, d_o2, 7'h00);
    chk({tag, " dout n1"}, d_n1, 8'h00);
    chk({tag, " parity_err"}, perr, 3'b000);
    chk({tag, " frame_err"}, ferr, 3'b000);
    chk({tag, " break_det"}, brk, 3'b000);
  endtask

  initial begin
    rec_t       e;
    logic [8:0] d;
    logic       fl, last_low;
    logic [1:0] slo;
    int         gap;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    send_frame(0, 9'h0A5, 1'b0, 2'b00, 2 * CPB, -1);
    check_q(0, "8E1 A5");
    send_frame(1, 9'h041, 1'b1, 2'b00, 2 * CPB, -1);
    check_q(1, "7O2 41 badpar");

    hold(2, 1'b0, 3);
    hold(2, 1'b1, 2 * CPB);
    send_frame(2, 9'h000, 1'b0, 2'b00, 2 * CPB, 3);
    check_q(2, "8N1 glitch");

    // A low stop bit keeps the line low, so the next start edge needs an idle bit;
    // 5A -> C3 is sent with no gap at all.
    send_frame(2, 9'h03C, 1'b0, 2'b01, CPB, -1);
    send_frame(2, 9'h05A, 1'b0, 2'b00, 0, -1);
    send_frame(2, 9'h0C3, 1'b0, 2'b00, 2 * CPB, -1);
    check_q(2, "8N1 stoperr/b2b");

    e = mk(cyc + 3 + 9 * CPB + HALF + 2, 9'h000, 1'b0, 1'b1, 1'b1);
    exp_q[2].push_back(e);
    hold(2, 1'b0, 20 * CPB);
    hold(2, 1'b1, 2 * CPB);
    send_frame(2, 9'h011, 1'b0, 2'b00, 2 * CPB, -1);
    check_q(2, "8N1 break");
    chk("dout held after frame", d_n1, 8'h11);

    hold(2, 1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(2, 1'b1, CPB);
    hold(2, 1'b1, CPB / 2);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async reset");
    @(posedge clk);
    #1;
    hold(2, 1'b1, 2);
    rst_n = 1'b1;
    hold(2, 1'b1, 5 * CPB);
    send_frame(2, 9'h081, 1'b0, 2'b00, 2 * CPB, -1);
    check_q(0, "after reset");
    check_q(1, "after reset");
    check_q(2, "8N1 81 after reset");

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 8; n++) begin
        d   = 9'($urandom);
        if ($urandom_range(0, 7) == 0) d = '0;
        fl  = 1'($urandom_range(0, 1));
        slo = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        if (sb[k] == 1) slo[1] = 1'b0;
        last_low = slo[sb[k] - 1];
        if (last_low) gap = CPB + int'($urandom_range(0, CPB));
        else          gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 2 * CPB));
        send_frame(k, d, fl, slo, gap, -1);
      end
      hold(k, 1'b1, 3 * CPB);
      check_q(k, "random");
    end

    check_q(0, "final");
    check_q(1, "final");
    check_q(2, "final");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
